// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, halt opcode and fetch FSM encoding shared by the PC,
// fetch and decode stages.
package fetch_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DBG_WAIT = 2'd1,
      DBG_STEP = 2'd2,
      HALT     = 2'd3
   } fetch_state_e;

   // Saturating 16-bit increment for event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC / PC-hold / imem address selection.
// Ports:
//   reset                        synchronous active-low reset level
//   state                        current fetch FSM state
//   stall                        hazard stall request
//   branch_taken/branch_target   ID redirect (wins over jump)
//   jump_taken/jump_target       ID redirect
//   pc_addr                      current PC value
//   req_pc                       address of the word in flight
//   next_pc                      next PC value
//   pc_not_enable                1 = PC holds
//   imem_addr                    instruction memory read address
module fetch_next_pc
   import fetch_pkg::*;
(
   input  logic              reset,
   input  fetch_state_e      state,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump_taken,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [ADDR_W-1:0] req_pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              pc_not_enable,
   output logic [ADDR_W-1:0] imem_addr
);

   logic hold;

   // Halt ignores redirects; otherwise a redirect overrides stall and debug hold.
   always_comb begin
      next_pc       = pc_addr;
      pc_not_enable = 1'b1;
      imem_addr     = req_pc;
      hold          = stall || (state == DBG_WAIT);
      if (!reset) begin
         next_pc   = '0;
         imem_addr = '0;
      end else if (state != HALT) begin
         if (branch_taken) begin
            next_pc       = branch_target;
            pc_not_enable = 1'b0;
            imem_addr     = pc_addr;
         end else if (jump_taken) begin
            next_pc       = jump_target;
            pc_not_enable = 1'b0;
            imem_addr     = pc_addr;
         end else if (!hold) begin
            next_pc       = pc_addr + 1'b1;
            pc_not_enable = 1'b0;
            imem_addr     = pc_addr;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between the PC and the IF/ID register.
// Drives the synchronous instruction memory, tracks the word in flight,
// loads IF/ID, and handles stall, redirect squash, halt and debug stepping.
// Ports:
//   clk, reset (sync, active-low)
//   pc_addr                  current PC value
//   next_pc, pc_not_enable   feedback to the PC (combinational)
//   imem_addr, imem_data     instruction memory (data valid one cycle later)
//   stall                    hazard stall
//   branch_*/jump_*          redirects from ID
//   debug_mode, debug_step   step-controlled execution
//   ifid_instr, ifid_pc_plus1, ifid_valid   IF/ID register
//   halted                   halt opcode fetched
//   fetch_count              saturating count of valid IF/ID loads
//
// state    | meaning
// RUN      | free-running fetch, one instruction per cycle
// DBG_WAIT | debug hold, waiting for a debug_step pulse
// DBG_STEP | one advancing edge, then back to DBG_WAIT
// HALT     | halt opcode loaded, fetch frozen until reset
module fetch_stage
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic [ADDR_W-1:0]  next_pc,
   output logic               pc_not_enable,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               jump_taken,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               debug_mode,
   input  logic               debug_step,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc_plus1,
   output logic               ifid_valid,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   fetch_state_e      state;
   logic              req_valid;
   logic [ADDR_W-1:0] req_pc;
   logic              redirect;
   logic              advance;
   logic              halt_load;

   assign redirect  = (branch_taken || jump_taken) && (state != HALT);
   assign advance   = !redirect && !stall && ((state == RUN) || (state == DBG_STEP));
   assign halt_load = advance && req_valid && (imem_data == HALT_OPCODE);

   fetch_next_pc u_next_pc (
      .reset         (reset),
      .state         (state),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .pc_addr       (pc_addr),
      .req_pc        (req_pc),
      .next_pc       (next_pc),
      .pc_not_enable (pc_not_enable),
      .imem_addr     (imem_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= RUN;
         req_valid     <= 1'b0;
         req_pc        <= '0;
         ifid_instr    <= '0;
         ifid_pc_plus1 <= '0;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
         fetch_count   <= '0;
      end else begin
         if (redirect) begin
            // Squash both the IF/ID word and the word in flight.
            ifid_valid <= 1'b0;
            req_valid  <= 1'b0;
         end else if ((state == HALT) || (!stall && (state == DBG_WAIT))) begin
            ifid_valid <= 1'b0;
         end else if (advance) begin
            ifid_instr    <= imem_data;
            ifid_pc_plus1 <= req_pc + 1'b1;
            ifid_valid    <= req_valid;
            req_pc        <= pc_addr;
            req_valid     <= 1'b1;
            if (req_valid) begin
               fetch_count <= sat_inc16(fetch_count);
            end
            if (halt_load) begin
               halted <= 1'b1;
            end
         end

         if (halt_load) begin
            state <= HALT;
         end else begin
            case (state)
               RUN:      if (debug_mode) state <= DBG_WAIT;
               DBG_WAIT: if (!debug_mode) state <= RUN;
                         else if (debug_step) state <= DBG_STEP;
               DBG_STEP: state <= debug_mode ? DBG_WAIT : RUN;
               HALT:     state <= HALT;
               default:  state <= RUN;
            endcase
         end
      end
   end

endmodule
